// File: rtl/ltssm_config_negotiator.sv
// rtl/ltssm_config_negotiator.sv - LTSSM Configuration negotiator; optional lane reversal via LTSSM_LANE_REVERSAL_EN
module ltssm_config_negotiator #(
  parameter int NUM_LANES    = 4,
  parameter int LINK_NUM     = 0,
  parameter int TIMEOUT_24MS = 3000000,
  parameter int TIMEOUT_2MS  = 250000,
  parameter int RX_REQ       = 8,
  parameter int TX_REQ       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [NUM_LANES-1:0]   lane_active_i,
  input  logic [NUM_LANES-1:0]   ts1_valid_i,
  input  logic [NUM_LANES-1:0]   ts2_valid_i,
  input  logic [NUM_LANES-1:0]   idle_valid_i,
  input  logic [NUM_LANES*8-1:0] link_num_i,
  input  logic [NUM_LANES*8-1:0] lane_num_i,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [1:0]             tx_type_o,
  output logic [NUM_LANES*8-1:0] tx_link_num_o,
  output logic [NUM_LANES*8-1:0] tx_lane_num_o,
  output logic [NUM_LANES-1:0]   config_lanes_o,
  output logic                   lane_reversed_o,
  output logic                   success_o,
  output logic                   error_o,
  output logic                   goto_recovery_o
);

  localparam logic [7:0]    PAD      = 8'hF7;
  localparam logic [7:0]    LINK     = 8'(LINK_NUM);
  localparam int            TW       = $clog2(TIMEOUT_24MS + 1);
  localparam int            WW       = $clog2(NUM_LANES) + 1;
  localparam logic [TW-1:0] T24_LAST = TW'(TIMEOUT_24MS - 1);
  localparam logic [TW-1:0] T2_LAST  = TW'(TIMEOUT_2MS - 1);
  localparam logic [3:0]    RX_SAT   = 4'(RX_REQ);
  localparam logic [4:0]    TX_SAT   = 5'(TX_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_LW_START, S_LW_ACCEPT, S_LN_WAIT,
    S_LN_ACCEPT, S_COMPLETE, S_CFG_IDLE, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [WW-1:0]          width_q, width_d;
  logic                   reversed_q, reversed_d;
  logic                   success_q, success_d;
  logic                   error_q, error_d;
  logic                   recovery_q, recovery_d;
  logic                   first_rx_q, first_rx_d;
  logic [4:0]             tx_cnt_q, tx_cnt_d;
  logic [NUM_LANES-1:0]   seen_q, seen_d;
  logic [3:0]             rx_cnt_q [NUM_LANES];
  logic [3:0]             rx_cnt_d [NUM_LANES];
  logic [7:0]             rx_lane_q [NUM_LANES];
  logic [7:0]             rx_lane_d [NUM_LANES];

  logic [7:0]             rx_link [NUM_LANES];
  logic [7:0]             rx_lane [NUM_LANES];
  logic [7:0]             exp_lane [NUM_LANES];
  logic [NUM_LANES-1:0]   cfg_mask;
  logic [NUM_LANES-1:0]   rx_any;
  logic [NUM_LANES-1:0]   rx_match;
  logic                   any_lw2, all_ln2, all_rx_req, fwd_ok, cfg_hit, prefix_ok;
  logic [WW-1:0]          w_new;
  logic                   xfer, can_move, entry;
`ifdef LTSSM_LANE_REVERSAL_EN
  logic                   rev_ok;
`endif

  // Ordered-set requests are live only in the states that actually stream to the partner.
  assign tx_valid_o      = (state_q == S_LW_START) || (state_q == S_LN_WAIT) ||
                           (state_q == S_COMPLETE) || (state_q == S_CFG_IDLE);
  assign xfer            = tx_valid_o && tx_ready_i;
  assign can_move        = !tx_valid_o || tx_ready_i;
  assign config_lanes_o  = cfg_mask;
  assign success_o       = success_q;
  assign error_o         = error_q;
  assign goto_recovery_o = recovery_q;
`ifdef LTSSM_LANE_REVERSAL_EN
  assign lane_reversed_o = reversed_q;
`else
  assign lane_reversed_o = 1'b0;
`endif

  // Per-lane decode: field slicing, configured-lane mask, expected lane number and receipt match.
  always_comb begin
    cfg_mask = '0;
    rx_any   = '0;
    rx_match = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rx_link[i]  = link_num_i[8*i +: 8];
      rx_lane[i]  = lane_num_i[8*i +: 8];
      cfg_mask[i] = (WW'(i) < width_q);
      exp_lane[i] = reversed_q ? 8'(width_q - WW'(1) - WW'(i)) : 8'(i);
      rx_any[i]   = lane_active_i[i] & (ts1_valid_i[i] | ts2_valid_i[i] | idle_valid_i[i]);
      case (state_q)
        S_LW_START: rx_match[i] = ts1_valid_i[i] && (rx_link[i] == LINK);
        S_LN_WAIT:  rx_match[i] = ts1_valid_i[i] && (rx_lane[i] != PAD);
        S_COMPLETE: rx_match[i] = ts2_valid_i[i] && (rx_link[i] == LINK) &&
                                  (rx_lane[i] == exp_lane[i]);
        S_CFG_IDLE: rx_match[i] = idle_valid_i[i];
        default:    rx_match[i] = 1'b0;
      endcase
      rx_match[i] = rx_match[i] & lane_active_i[i];
    end
  end

  // Lane-set summaries used by the exit conditions, plus the widest power-of-two prefix of good lanes.
  always_comb begin
    any_lw2    = 1'b0;
    all_ln2    = 1'b1;
    all_rx_req = 1'b1;
    fwd_ok     = 1'b1;
    cfg_hit    = 1'b0;
    prefix_ok  = 1'b1;
    w_new      = '0;
`ifdef LTSSM_LANE_REVERSAL_EN
    rev_ok     = (width_q > WW'(1));
`endif
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_active_i[i] && (rx_cnt_q[i] >= 4'd2)) any_lw2 = 1'b1;
      if (cfg_mask[i]) begin
        if (rx_cnt_q[i] < 4'd2)    all_ln2    = 1'b0;
        if (rx_cnt_q[i] != RX_SAT) all_rx_req = 1'b0;
        if (rx_lane_q[i] != 8'(i)) fwd_ok     = 1'b0;
`ifdef LTSSM_LANE_REVERSAL_EN
        if (rx_lane_q[i] != 8'(width_q - WW'(1) - WW'(i))) rev_ok = 1'b0;
`endif
        if (rx_match[i]) cfg_hit = 1'b1;
      end
      prefix_ok = prefix_ok & lane_active_i[i] & seen_q[i];
      if (prefix_ok && (((i + 1) & i) == 0)) w_new = WW'(i + 1);
    end
  end

  // Next-state logic; transitions wait for a free transmit slot, en_i low overrides everything.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    reversed_d = reversed_q;
    success_d  = 1'b0;
    error_d    = 1'b0;
    recovery_d = 1'b0;
    if (!en_i) begin
      state_d    = S_IDLE;
      width_d    = '0;
      reversed_d = 1'b0;
    end else if (can_move) begin
      case (state_q)
        S_IDLE: state_d = S_LW_START;
        S_LW_START: begin
          if (any_lw2) begin
            state_d = S_LW_ACCEPT;
            width_d = w_new;
          end else if (timer_q >= T24_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        // A zero width means lane 0 never qualified, so no link can be formed.
        S_LW_ACCEPT: begin
          if (width_q == '0) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LN_WAIT;
          end
        end
        S_LN_WAIT: begin
          if (all_ln2) begin
            state_d = S_LN_ACCEPT;
          end else if (timer_q >= T2_LAST) begin
            state_d = S_LW_START;
            width_d = '0;
          end
        end
        S_LN_ACCEPT: begin
          if (fwd_ok) begin
            state_d = S_COMPLETE;
          end
`ifdef LTSSM_LANE_REVERSAL_EN
          else if (rev_ok) begin
            reversed_d = 1'b1;
            state_d    = S_COMPLETE;
          end
`endif
          else if (width_q > WW'(1)) begin
            width_d = width_q >> 1;
            state_d = S_LN_WAIT;
          end else begin
            error_d = 1'b1;
            width_d = '0;
            state_d = S_IDLE;
          end
        end
        S_COMPLETE: begin
          if (all_rx_req && (tx_cnt_q == TX_SAT)) begin
            state_d = S_CFG_IDLE;
          end else if (timer_q >= T2_LAST) begin
            error_d    = 1'b1;
            width_d    = '0;
            reversed_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        S_CFG_IDLE: begin
          if (all_rx_req && (tx_cnt_q == TX_SAT)) begin
            success_d = 1'b1;
            state_d   = S_DONE;
          end else if (timer_q >= T2_LAST) begin
            recovery_d = 1'b1;
            state_d    = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign entry = (state_d != state_q);

  // Timer, receipt counters and transfer counter; all restart whenever a new state is entered.
  always_comb begin
    timer_d    = entry ? '0 : ((timer_q != {TW{1'b1}}) ? timer_q + TW'(1) : timer_q);
    first_rx_d = entry ? 1'b0 : (first_rx_q | cfg_hit);
    tx_cnt_d   = tx_cnt_q;
    if (entry) begin
      tx_cnt_d = '0;
    end else if (xfer && first_rx_q && (tx_cnt_q != TX_SAT)) begin
      tx_cnt_d = tx_cnt_q + 5'd1;
    end
    seen_d = seen_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      rx_cnt_d[i]  = rx_cnt_q[i];
      rx_lane_d[i] = rx_lane_q[i];
      if (entry) begin
        rx_cnt_d[i] = 4'd0;
        seen_d[i]   = 1'b0;
      end else begin
        if (rx_any[i]) begin
          if (rx_match[i]) begin
            rx_cnt_d[i] = (rx_cnt_q[i] == RX_SAT) ? rx_cnt_q[i] : rx_cnt_q[i] + 4'd1;
          end else begin
            rx_cnt_d[i] = 4'd0;
          end
        end
        if ((state_q == S_LW_START) && rx_match[i]) seen_d[i] = 1'b1;
      end
      if ((state_q == S_LN_WAIT) && rx_match[i]) rx_lane_d[i] = rx_lane[i];
    end
  end

  // Transmit fields: link advertised on usable lanes, lane numbers once a width is chosen, PAD elsewhere.
  always_comb begin
    tx_type_o     = 2'd0;
    tx_link_num_o = '0;
    tx_lane_num_o = '0;
    case (state_q)
      S_COMPLETE: tx_type_o = 2'd1;
      S_CFG_IDLE: tx_type_o = 2'd2;
      default:    tx_type_o = 2'd0;
    endcase
    for (int i = 0; i < NUM_LANES; i++) begin
      case (state_q)
        S_LW_START: begin
          tx_link_num_o[8*i +: 8] = lane_active_i[i] ? LINK : PAD;
          tx_lane_num_o[8*i +: 8] = PAD;
        end
        S_LW_ACCEPT, S_LN_WAIT, S_LN_ACCEPT, S_COMPLETE, S_CFG_IDLE: begin
          tx_link_num_o[8*i +: 8] = cfg_mask[i] ? LINK : PAD;
          tx_lane_num_o[8*i +: 8] = cfg_mask[i] ? exp_lane[i] : PAD;
        end
        default: begin
          tx_link_num_o[8*i +: 8] = 8'h00;
          tx_lane_num_o[8*i +: 8] = 8'h00;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      width_q    <= '0;
      reversed_q <= 1'b0;
      success_q  <= 1'b0;
      error_q    <= 1'b0;
      recovery_q <= 1'b0;
      first_rx_q <= 1'b0;
      tx_cnt_q   <= '0;
      seen_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rx_cnt_q[i]  <= 4'd0;
        rx_lane_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      width_q    <= width_d;
      reversed_q <= reversed_d;
      success_q  <= success_d;
      error_q    <= error_d;
      recovery_q <= recovery_d;
      first_rx_q <= first_rx_d;
      tx_cnt_q   <= tx_cnt_d;
      seen_q     <= seen_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        rx_cnt_q[i]  <= rx_cnt_d[i];
        rx_lane_q[i] <= rx_lane_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ltssm_config_negotiator.sv
// tb/tb_ltssm_config_negotiator.sv - directed bench for ltssm_config_negotiator
module tb_ltssm_config_negotiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  active, ts1, ts2, idl;
  logic [31:0] link_in, lane_in;
  logic        tx_ready;
  logic        tx_valid;
  logic [1:0]  tx_type;
  logic [31:0] tx_link, tx_lane;
  logic [3:0]  cfg;
  logic        rev, succ, err, rec;

  int errors = 0;
  int checks = 0;

  ltssm_config_negotiator #(
    .NUM_LANES(4), .LINK_NUM(0), .TIMEOUT_24MS(200), .TIMEOUT_2MS(50),
    .RX_REQ(8), .TX_REQ(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .lane_active_i(active),
    .ts1_valid_i(ts1), .ts2_valid_i(ts2), .idle_valid_i(idl),
    .link_num_i(link_in), .lane_num_i(lane_in),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_type_o(tx_type),
    .tx_link_num_o(tx_link), .tx_lane_num_o(tx_lane),
    .config_lanes_o(cfg), .lane_reversed_o(rev), .success_o(succ),
    .error_o(err), .goto_recovery_o(rec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = TS1, 1 = TS2, 2 = idle; one-cycle strobe on the lanes in m
  task automatic strobe(input int kind, input logic [3:0] m, input logic [31:0] lanes, input int n);
    for (int k = 0; k < n; k++) begin
      link_in = 32'h0;
      lane_in = lanes;
      ts1 = (kind == 0) ? m : 4'b0;
      ts2 = (kind == 1) ? m : 4'b0;
      idl = (kind == 2) ? m : 4'b0;
      tick();
      ts1 = 4'b0; ts2 = 4'b0; idl = 4'b0;
    end
  endtask

  task automatic enter_ln_wait();
    en = 1'b1;
    active = 4'hF;
    tick();
    strobe(0, 4'hF, 32'hF7F7F7F7, 2);
    tick();
    tick();
  endtask

  task automatic to_complete();
    enter_ln_wait();
    strobe(0, 4'hF, 32'h03020100, 2);
    tick();
    tick();
  endtask

  task automatic abort_link();
    en = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; active = 4'h0; tx_ready = 1'b1;
    ts1 = 4'b0; ts2 = 4'b0; idl = 4'b0; link_in = 32'h0; lane_in = 32'h0;
    tick(); tick();
    checks++;
    if ({tx_valid, tx_type, tx_link, tx_lane, cfg, rev, succ, err, rec} !== 75'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {tx_valid, tx_type, tx_link, tx_lane, cfg, rev, succ, err, rec});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_no_tx: got %b expected 0", tx_valid); end
  endtask

  task automatic test_happy_path();
    en = 1'b1; active = 4'hF;
    tick();
    checks++;
    if ({tx_valid, tx_type, tx_link, tx_lane} !== {1'b1, 2'd0, 32'h0, 32'hF7F7F7F7}) begin
      errors++; $display("FAIL lw_start_tx: got %h %h %h %h expected 1 0 0 f7f7f7f7", tx_valid, tx_type, tx_link, tx_lane);
    end
    strobe(0, 4'hF, 32'hF7F7F7F7, 2);
    tick();
    checks++;
    if ({cfg, tx_valid} !== {4'hF, 1'b0}) begin
      errors++; $display("FAIL lw_accept: got cfg=%h valid=%b expected f 0", cfg, tx_valid);
    end
    tick();
    checks++;
    if ({tx_valid, tx_lane} !== {1'b1, 32'h03020100}) begin
      errors++; $display("FAIL ln_wait_lanes: got %b %h expected 1 03020100", tx_valid, tx_lane);
    end
    strobe(0, 4'hF, 32'h03020100, 2);
    tick(); tick();
    checks++;
    if (tx_type !== 2'd1) begin errors++; $display("FAIL enter_complete: got %0d expected 1", tx_type); end
    strobe(1, 4'hF, 32'h03020100, 8);
    repeat (9) tick();
    checks++;
    if (tx_type !== 2'd1) begin errors++; $display("FAIL complete_tx_count: got %0d expected 1", tx_type); end
    tick();
    checks++;
    if (tx_type !== 2'd2) begin errors++; $display("FAIL enter_cfg_idle: got %0d expected 2", tx_type); end
    strobe(2, 4'hF, 32'h0, 8);
    repeat (9) tick();
    checks++;
    if ({succ, tx_valid} !== 2'b01) begin errors++; $display("FAIL idle_wait: got succ=%b valid=%b expected 0 1", succ, tx_valid); end
    tick();
    checks++;
    if ({succ, tx_valid, cfg, err} !== {1'b1, 1'b0, 4'hF, 1'b0}) begin
      errors++; $display("FAIL success: got succ=%b valid=%b cfg=%h err=%b expected 1 0 f 0", succ, tx_valid, cfg, err);
    end
    tick();
    checks++;
    if ({succ, cfg} !== {1'b0, 4'hF}) begin errors++; $display("FAIL done_hold: got succ=%b cfg=%h expected 0 f", succ, cfg); end
    en = 1'b0;
    tick();
    checks++;
    if ({cfg, tx_valid} !== 5'h0) begin errors++; $display("FAIL en_low_done: got cfg=%h valid=%b expected 0 0", cfg, tx_valid); end
    tick();
  endtask

  task automatic test_downsize();
    enter_ln_wait();
    strobe(0, 4'hF, 32'h02030100, 2);
    tick(); tick();
    checks++;
    if ({cfg, tx_valid, tx_type, tx_link, tx_lane} !== {4'h3, 1'b1, 2'd0, 32'hF7F70000, 32'hF7F70100}) begin
      errors++; $display("FAIL downsize_w2: got cfg=%h %b %0d %h %h expected 3 1 0 f7f70000 f7f70100", cfg, tx_valid, tx_type, tx_link, tx_lane);
    end
    strobe(0, 4'h3, 32'h02030100, 2);
    tick(); tick();
    checks++;
    if (tx_type !== 2'd1) begin errors++; $display("FAIL downsize_complete: got %0d expected 1", tx_type); end
    strobe(1, 4'h3, 32'h00000100, 8);
    repeat (10) tick();
    checks++;
    if (tx_type !== 2'd2) begin errors++; $display("FAIL downsize_cfg_idle: got %0d expected 2", tx_type); end
    strobe(2, 4'h3, 32'h0, 8);
    repeat (10) tick();
    checks++;
    if ({succ, cfg} !== {1'b1, 4'h3}) begin errors++; $display("FAIL downsize_success: got succ=%b cfg=%h expected 1 3", succ, cfg); end
    abort_link();
  endtask

  task automatic test_lw_timeout();
    en = 1'b1; active = 4'hF;
    tick();
    repeat (199) tick();
    checks++;
    if ({err, tx_valid} !== 2'b01) begin errors++; $display("FAIL lw_timeout_early: got err=%b valid=%b expected 0 1", err, tx_valid); end
    tick();
    checks++;
    if ({err, tx_valid, cfg} !== {1'b1, 1'b0, 4'h0}) begin
      errors++; $display("FAIL lw_timeout: got err=%b valid=%b cfg=%h expected 1 0 0", err, tx_valid, cfg);
    end
    abort_link();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL error_pulse: got %b expected 0", err); end
  endtask

  task automatic test_idle_timeout();
    to_complete();
    strobe(1, 4'hF, 32'h03020100, 8);
    repeat (10) tick();
    repeat (49) tick();
    checks++;
    if ({rec, tx_type} !== {1'b0, 2'd2}) begin errors++; $display("FAIL idle_timeout_early: got rec=%b type=%0d expected 0 2", rec, tx_type); end
    tick();
    checks++;
    if ({rec, tx_valid, cfg, succ} !== {1'b1, 1'b0, 4'hF, 1'b0}) begin
      errors++; $display("FAIL idle_timeout: got rec=%b valid=%b cfg=%h succ=%b expected 1 0 f 0", rec, tx_valid, cfg, succ);
    end
    abort_link();
  endtask

  task automatic test_backpressure();
    to_complete();
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ts2 = (k < 8) ? 4'hF : 4'h0;
      lane_in = 32'h03020100;
      tick();
      ts2 = 4'h0;
      checks++;
      if ({tx_valid, tx_type, tx_link, tx_lane} !== {1'b1, 2'd1, 32'h0, 32'h03020100}) begin
        errors++; $display("FAIL stall_hold[%0d]: got %b %0d %h %h expected 1 1 0 03020100", k, tx_valid, tx_type, tx_link, tx_lane);
      end
    end
    tx_ready = 1'b1;
    repeat (16) tick();
    checks++;
    if (tx_type !== 2'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", tx_type); end
    tick();
    checks++;
    if (tx_type !== 2'd2) begin errors++; $display("FAIL stall_release: got %0d expected 2", tx_type); end
    abort_link();
  endtask

  task automatic test_reversal();
    enter_ln_wait();
    strobe(0, 4'hF, 32'h00010203, 2);
    tick(); tick();
`ifdef LTSSM_LANE_REVERSAL_EN
    checks++;
    if ({rev, cfg, tx_type, tx_lane} !== {1'b1, 4'hF, 2'd1, 32'h00010203}) begin
      errors++; $display("FAIL reversal: got rev=%b cfg=%h type=%0d lane=%h expected 1 f 1 00010203", rev, cfg, tx_type, tx_lane);
    end
`else
    checks++;
    if ({rev, cfg, tx_type} !== {1'b0, 4'h3, 2'd0}) begin
      errors++; $display("FAIL reversal_downsize: got rev=%b cfg=%h type=%0d expected 0 3 0", rev, cfg, tx_type);
    end
`endif
    abort_link();
  endtask

  task automatic test_abort();
    to_complete();
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL abort_pre: got %b expected 1", tx_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_valid, tx_type, tx_link, tx_lane, cfg, rev, succ, err, rec} !== 75'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {tx_valid, tx_type, tx_link, tx_lane, cfg, rev, succ, err, rec});
    end
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    enter_ln_wait();
    checks++;
    if ({tx_valid, cfg} !== {1'b1, 4'hF}) begin errors++; $display("FAIL ln_wait_pre: got %b %h expected 1 f", tx_valid, cfg); end
    en = 1'b0;
    tick();
    checks++;
    if ({tx_valid, cfg, tx_lane} !== {1'b0, 4'h0, 32'h0}) begin
      errors++; $display("FAIL en_abort: got %b %h %h expected 0 0 0", tx_valid, cfg, tx_lane);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_downsize();
    test_lw_timeout();
    test_idle_timeout();
    test_backpressure();
    test_reversal();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ltssm_config_negotiator.md
Name: ltssm_config_negotiator

Overview:
- Parametrised downstream-port LTSSM Configuration sub-state machine: Linkwidth.Start → Lanenum.Wait/Accept → Complete → Idle.
- Generalises the 4-lane configuration block to NUM_LANES lanes and configurable timeouts and counts.
- Adds link-width downsizing on lane-number mismatch, plus optional lane reversal.
- Sits between per-lane ordered-set receivers and the TS/IDLE transmit generator; reports the negotiated width to the LTSSM top.

Parameters:
- NUM_LANES, 4, lane count; power of two, 1..16.
- LINK_NUM, 0, link number advertised in transmitted TS1/TS2.
- TIMEOUT_24MS, 3000000, cycles for the Linkwidth.Start timeout.
- TIMEOUT_2MS, 250000, cycles for the Lanenum, Complete and Idle timeouts.
- RX_REQ, 8, consecutive matching receipts required per lane in Complete/Idle.
- TX_REQ, 16, transfers required after the first matching receipt in Complete/Idle.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- en_i  in  1  enter/stay in Configuration.
- lane_active_i  in  NUM_LANES  lanes that passed Detect/Polling.
- ts1_valid_i  in  NUM_LANES  TS1 received on lane, 1-cycle strobe.
- ts2_valid_i  in  NUM_LANES  TS2 received on lane, 1-cycle strobe.
- idle_valid_i  in  NUM_LANES  idle symbol block received on lane.
- link_num_i  in  NUM_LANES*8  received link number per lane.
- lane_num_i  in  NUM_LANES*8  received lane number per lane.
- tx_valid_o  out  1  ordered-set transmit request.
- tx_ready_i  in  1  transmitter accepts request.
- tx_type_o  out  2  0=TS1, 1=TS2, 2=IDLE.
- tx_link_num_o  out  NUM_LANES*8  link field per lane; 8'hF7 = PAD.
- tx_lane_num_o  out  NUM_LANES*8  lane field per lane; 8'hF7 = PAD.
- config_lanes_o  out  NUM_LANES  mask of configured lanes.
- lane_reversed_o  out  1  configured lanes are reversed.
- success_o  out  1  1-cycle pulse: Configuration complete.
- error_o  out  1  1-cycle pulse: fail; LTSSM returns to Detect.
- goto_recovery_o  out  1  1-cycle pulse: Idle timeout.

Interface rule: one clock, clk_i; reset rst_i is asynchronous, active-high.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters 0.
- Handshake:
  - A transfer occurs when tx_valid_o && tx_ready_i.
  - tx fields are stable while tx_valid_o && !tx_ready_i.
  - State changes are taken only on cycles with (!tx_valid_o || tx_ready_i).
  - en_i low forces IDLE next cycle regardless, clearing tx_valid_o, config_lanes_o and lane_reversed_o.
- Timer:
  - Cleared on every state entry and counts each cycle.
  - Timeout fires when timer == limit-1.
- Per-lane RX counter (4b, saturating at RX_REQ):
  - Increments on each matching receipt.
  - Clears on a non-matching receipt.
  - Holds on cycles without a receipt.
  - Clears on state entry.
- TX counter (5b, saturating at TX_REQ):
  - Counts transfers after the first matching receipt in the state.
- States:
  - IDLE:
    - Outputs idle.
    - en_i → LW_START.
  - LW_START:
    - TX TS1, link=LINK_NUM, lane=PAD on active lanes; PAD/PAD on inactive lanes.
    - When any active lane has 2 consecutive TS1 with link_num_i==LINK_NUM → LW_ACCEPT.
    - Timeout 24ms → error_o, IDLE.
  - LW_ACCEPT (one cycle):
    - W = largest power of two ≤ NUM_LANES such that lanes 0..W-1 are all active and have ≥1 matching TS1.
    - config_lanes_o = low W bits set.
    - Lane i transmits lane number i (i<W); others transmit PAD/PAD.
    - → LN_WAIT.
  - LN_WAIT:
    - TX TS1 with lane numbers.
    - When every configured lane has 2 consecutive TS1 with non-PAD lane_num_i → LN_ACCEPT.
    - Timeout 2ms → LW_START.
  - LN_ACCEPT (one cycle):
    - Received lane i == i for all configured lanes → COMPLETE.
    - Otherwise, W>1 → W=W/2, update config_lanes_o, → LN_WAIT.
    - Otherwise (W==1) → error_o, IDLE.
  - COMPLETE:
    - TX TS2 with the same fields.
    - Exit when every configured lane has RX_REQ consecutive TS2 with matching link/lane and the TX counter == TX_REQ → CFG_IDLE.
    - Timeout 2ms → error_o, IDLE.
  - CFG_IDLE:
    - TX IDLE.
    - Exit when every configured lane has RX_REQ consecutive idle_valid_i and the TX counter == TX_REQ → success_o, DONE.
    - Timeout 2ms → goto_recovery_o, DONE.
  - DONE:
    - tx_valid_o=0; config_lanes_o and lane_reversed_o held.
    - en_i low → IDLE.
- Simultaneous events:
  - Completion condition and timeout in the same cycle: completion wins.
  - Receipt strobes on inactive lanes are ignored.

Optional Feature:
- Macro: LTSSM_LANE_REVERSAL_EN.
- Defined:
  - In LN_ACCEPT, received lane i == W-1-i on all configured lanes (W>1) sets lane_reversed_o=1 → COMPLETE.
  - Transmitted lane numbers are reversed from the next cycle.
  - TS2 matching in COMPLETE uses the reversed numbering.
- Undefined:
  - The reversed pattern is treated as a mismatch and triggers downsizing.
  - lane_reversed_o is tied 0.

Test Plan (NUM_LANES=4, TIMEOUT_24MS=200, TIMEOUT_2MS=50, tx_ready_i=1 unless stated):
- Happy path: 4 active lanes, partner echoes link 0 and lanes 0..3, then TS2 x8 and idle x8 → config_lanes_o=4'b1111, success_o single pulse, state DONE; en_i low → IDLE.
- Downsizing: partner returns lane numbers 0,1,3,2 → width drops to 2, config_lanes_o=4'b0011; partner then returns 0,1 → success_o.
- Timeouts:
  - No TS1 received → error_o at cycle 200 after entry.
  - Idle never received → goto_recovery_o 50 cycles after CFG_IDLE entry.
- Backpressure: tx_ready_i=0 for 10 cycles in COMPLETE → tx_valid_o held, fields stable, no state change until a ready cycle.
- Reversal: partner returns lanes 3,2,1,0.
  - With LTSSM_LANE_REVERSAL_EN: lane_reversed_o=1, width 4.
  - Without: width drops to 2.
- Abort: rst_i asserted mid-COMPLETE → all outputs 0 immediately. Separately, en_i low mid-LN_WAIT → IDLE next cycle, tx_valid_o=0.
